// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing default, ASCII control codes,
// bit-receiver state encoding and hex-decode helpers.
package uart_pkg;

  localparam int         BAUD_DIV_DEFAULT = 218;
  localparam logic [7:0] ASCII_LF         = 8'h0A;
  localparam logic [7:0] ASCII_CR         = 8'h0D;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // One entry of the output byte stream.
  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  // True for 0-9, A-F, a-f.
  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Nibble value of a character already known to be hex. Letters have
  // bit 6 set and their low nibble runs 1..6, so add 9 to reach A..F.
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    return c[6] ? (c[3:0] + 4'd9) : c[3:0];
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 character receiver: 2-flop synchroniser, falling-edge start detect,
// mid-bit sampling. Emits one strobe per good character and a framing
// error strobe when the stop bit is sampled low. BAUD_DIV must be >= 16.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic       rx_framing_err
);

  localparam int             CW   = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]  FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]  HALF = CW'(BAUD_DIV / 2 - 1);

  logic [1:0]    sync_q;
  logic [1:0]    sync_vld;
  logic          line_q;
  logic          armed_q;
  logic          rx_s;
  logic          fall;

  rx_state_t     state_q, state_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [2:0]    bit_q, bit_nxt;
  logic [7:0]    shift_q, shift_nxt;
  logic [7:0]    data_q, data_nxt;
  logic          strobe_q, strobe_nxt;
  logic          ferr_q, ferr_nxt;

  assign rx_s = sync_q[1];
  // The synchroniser resets to idle-high, so a line that is already low
  // when reset releases would look like a start edge. Edges only count
  // once the line has been genuinely seen high after reset.
  assign fall = armed_q & line_q & ~rx_s;

  // Synchroniser, previous-sample register and post-reset arming.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      sync_q   <= 2'b11;
      sync_vld <= 2'b00;
      line_q   <= 1'b1;
      armed_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], uart_rx};
      sync_vld <= {sync_vld[0], 1'b1};
      line_q   <= rx_s;
      if (sync_vld[1] && rx_s) armed_q <= 1'b1;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      bit_q    <= bit_nxt;
      shift_q  <= shift_nxt;
      data_q   <= data_nxt;
      strobe_q <= strobe_nxt;
      ferr_q   <= ferr_nxt;
    end
  end

  // Next-state: count down to each sample point, sample, reload.
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    bit_nxt    = bit_q;
    shift_nxt  = shift_q;
    data_nxt   = data_q;
    strobe_nxt = 1'b0;
    ferr_nxt   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          cnt_nxt   = HALF;
          state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_nxt = RX_IDLE;          // glitch, not a start bit
          end else begin
            cnt_nxt   = FULL;
            bit_nxt   = '0;
            state_nxt = RX_DATA;
          end
        end else begin
          cnt_nxt = cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_nxt = {rx_s, shift_q[7:1]};  // LSB arrives first
          cnt_nxt   = FULL;
          bit_nxt   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_nxt = RX_STOP;
        end else begin
          cnt_nxt = cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            data_nxt   = shift_q;
            strobe_nxt = 1'b1;
            state_nxt  = RX_IDLE;
          end else begin
            ferr_nxt   = 1'b1;
            state_nxt  = RX_WAIT_HIGH;  // avoid restarting mid-break
          end
        end else begin
          cnt_nxt = cnt_q - CW'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  assign rx_data        = data_q;
  assign rx_strobe      = strobe_q;
  assign rx_framing_err = ferr_q;

endmodule

// File: rtl/uart_hex_rx.sv
// Hex-line receiver: turns ASCII hex pairs on the debug UART into a
// valid/ready byte stream. Each byte is held back one slot so the line
// feed can tag the final byte with last.
module uart_hex_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       err_framing,
  output logic       err_hex,
  output logic       overflow
);

  logic [7:0] rx_data;
  logic       rx_strobe;
  logic       rx_framing_err;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk_50         (clk_50),
    .reset          (reset),
    .uart_rx        (uart_rx),
    .rx_data        (rx_data),
    .rx_strobe      (rx_strobe),
    .rx_framing_err (rx_framing_err)
  );

  // Decode state: half-assembled nibble and the held-back byte.
  logic [3:0] nib_q, nib_nxt;
  logic       have_nib_q, have_nib_nxt;
  logic [7:0] pend_q, pend_nxt;
  logic       pend_vld_q, pend_vld_nxt;
  logic       push;
  beat_t      push_beat;
  logic       hex_err;

  // Output register.
  beat_t      out_q;
  logic       out_vld_q;
  logic       err_hex_q;
  logic       ovf_q;
  logic       accept;

  assign accept = out_vld_q & out_ready;

  // Character decode: nibble assembly, pending-byte handoff, line end.
  always_comb begin
    nib_nxt      = nib_q;
    have_nib_nxt = have_nib_q;
    pend_nxt     = pend_q;
    pend_vld_nxt = pend_vld_q;
    push         = 1'b0;
    push_beat    = '0;
    hex_err      = 1'b0;
    if (rx_strobe) begin
      if (is_hex(rx_data)) begin
        if (have_nib_q) begin
          // Byte complete: the older pending byte is now known not-last.
          push           = pend_vld_q;
          push_beat.data = pend_q;
          push_beat.last = 1'b0;
          pend_nxt       = {nib_q, hex_val(rx_data)};
          pend_vld_nxt   = 1'b1;
          have_nib_nxt   = 1'b0;
        end else begin
          nib_nxt      = hex_val(rx_data);
          have_nib_nxt = 1'b1;
        end
      end else if (rx_data == ASCII_LF) begin
        hex_err        = have_nib_q;     // odd nibble count on the line
        have_nib_nxt   = 1'b0;
        push           = pend_vld_q;
        push_beat.data = pend_q;
        push_beat.last = 1'b1;
        pend_vld_nxt   = 1'b0;
      end else if (rx_data != ASCII_CR) begin
        hex_err      = 1'b1;
        have_nib_nxt = 1'b0;
      end
    end
  end

  // Decode registers.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      nib_q      <= '0;
      have_nib_q <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      nib_q      <= nib_nxt;
      have_nib_q <= have_nib_nxt;
      pend_q     <= pend_nxt;
      pend_vld_q <= pend_vld_nxt;
    end
  end

  // Single-entry output register; a push into a stalled entry is dropped.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
      err_hex_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      err_hex_q <= hex_err;
      ovf_q     <= 1'b0;
      if (push) begin
        if (out_vld_q && !out_ready) begin
          ovf_q <= 1'b1;
        end else begin
          out_q     <= push_beat;
          out_vld_q <= 1'b1;
        end
      end else if (accept) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign out_data    = out_q.data;
  assign out_last    = out_q.last;
  assign out_valid   = out_vld_q;
  assign err_hex     = err_hex_q;
  assign overflow    = ovf_q;
  assign err_framing = rx_framing_err;

endmodule

// File: tb/tb_uart_hex_rx.sv
// Bench for uart_hex_rx: serial stimulus, line-level reference model
// feeding a scoreboard, monitor popping on each handshake.
module tb_uart_hex_rx;

  localparam int BD = 112;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx = 1'b1;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       err_framing;
  logic       err_hex;
  logic       overflow;

  uart_hex_rx #(.BAUD_DIV(BD)) dut (
    .clk_50      (clk_50),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .err_framing (err_framing),
    .err_hex     (err_hex),
    .overflow    (overflow)
  );

  always #10 clk_50 = ~clk_50;

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_pass = 0;
  int exp_fe = 0, exp_he = 0, exp_ov = 0;
  int got_fe = 0, got_he = 0, got_ov = 0;
  int char_start = 0;
  logic vld_q = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  task automatic send_char(input logic [7:0] c, input logic stop);
    char_start = cyc;
    uart_rx = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      uart_rx = c[i];
      tick(BD);
    end
    uart_rx = stop;
    tick(BD);
    uart_rx = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b1);
  endtask

  // Reference: split the line into hex pairs; every completed byte of a
  // line is emitted at the line feed, the final one marked last.
  task automatic send_line(input string s);
    logic [3:0] nibs[$];
    logic [7:0] bytes[$];
    logic [7:0] c;
    logic [3:0] v;
    bit ish;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      ish = 1'b1;
      if (c >= 8'h30 && c <= 8'h39)      v = 4'(c - 8'h30);
      else if (c >= 8'h41 && c <= 8'h46) v = 4'(c - 8'h41 + 8'd10);
      else if (c >= 8'h61 && c <= 8'h66) v = 4'(c - 8'h61 + 8'd10);
      else ish = 1'b0;
      if (ish) begin
        nibs.push_back(v);
        if (nibs.size() == 2) begin
          bytes.push_back({nibs[0], nibs[1]});
          nibs.delete();
        end
      end else if (c == 8'h0D) begin
      end else if (c == 8'h0A) begin
        if (nibs.size() != 0) exp_he++;
        nibs.delete();
        for (int k = 0; k < bytes.size(); k++)
          exp_q.push_back('{bytes[k], (k == bytes.size() - 1)});
        bytes.delete();
      end else begin
        exp_he++;
        nibs.delete();
      end
    end
    send_str(s);
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n, input bit upper);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return (upper ? 8'h41 : 8'h61) + 8'(n) - 8'd10;
  endfunction

  // Monitor: error pulse counts, first-cycle latency, scoreboard pops.
  initial begin
    int lat;
    exp_t e;
    forever begin
      @(negedge clk_50);
      if (!reset) begin
        if (err_framing) got_fe++;
        if (err_hex) got_he++;
        if (overflow) got_ov++;
        if (out_valid && !vld_q) begin
          lat = cyc - char_start;
          n_chk++;
          if (lat >= 9 * BD + BD / 2 + 2 && lat <= 9 * BD + BD / 2 + 6) n_pass++;
          else $display("FAIL latency: got %0d cycles from start edge, required %0d..%0d",
                        lat, 9 * BD + BD / 2 + 2, 9 * BD + BD / 2 + 6);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_beat: got data 0x%02h last %0d, required no beat",
                     out_data, out_last);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", out_data, e.d);
            chk("beat_last", out_last, e.l);
          end
        end
        vld_q = out_valid;
      end else begin
        vld_q = 1'b0;
      end
    end
  end

  // Watchdog: stimulus is fixed-length, so this only guards a broken run.
  initial begin
    #(95000 * 20);
    $display("FAIL watchdog: simulation ran past its cycle budget");
    $fatal(1);
  end

  initial begin
    string s;
    logic [7:0] b;
    int nb;

    // Reset values.
    tick(4);
    @(negedge clk_50);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_errs", {err_framing, err_hex, overflow}, 0);
    @(posedge clk_50); #1;
    reset = 1'b0;
    tick(BD);

    // Single byte line, then two bytes with a CR.
    send_line("A5\n");
    tick(BD);
    send_line("01fF\r\n");
    tick(BD);

    // Framing error: bad character discarded, next line clean.
    send_char(8'h41, 1'b0);
    tick(2 * BD);
    exp_fe++;
    chk("framing_count", got_fe, exp_fe);
    send_line("77\n");
    tick(BD);

    // Short low glitch must not start a character.
    uart_rx = 1'b0;
    tick(50);
    uart_rx = 1'b1;
    tick(3 * BD);
    chk("glitch_fe", got_fe, exp_fe);
    chk("glitch_he", got_he, exp_he);

    // Illegal character and odd nibble at line feed.
    send_line("1G23\n");
    send_line("1\n");
    tick(BD);
    chk("hex_err_count", got_he, exp_he);

    // Stalled consumer: first byte held, the next two dropped.
    out_ready = 1'b0;
    exp_q.push_back('{8'h11, 1'b0});
    exp_ov += 2;
    send_str("112233\n");
    tick(BD);
    @(negedge clk_50);
    chk("ovf_count", got_ov, exp_ov);
    chk("held_valid", out_valid, 1);
    chk("held_data", out_data, 8'h11);
    chk("held_last", out_last, 0);
    @(posedge clk_50); #1;
    out_ready = 1'b1;
    tick(BD);
    chk("ovf_drained", exp_q.size(), 0);

    // Reset with a held beat and a character mid-DATA.
    out_ready = 1'b0;
    send_line("9A\n");
    tick(8);
    char_start = cyc;
    uart_rx = 1'b0;
    tick(3 * BD + BD / 2);
    reset = 1'b1;
    tick(3);
    @(negedge clk_50);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_last", out_last, 0);
    void'(exp_q.pop_front());
    @(posedge clk_50); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    tick(5 * BD);
    uart_rx = 1'b1;
    tick(2 * BD);
    chk("midrst_no_char", exp_q.size(), 0);
    send_line("42\n");
    tick(BD);

    // Randomised lines, mixed case, optional junk prefix and CR.
    for (int ln = 0; ln < 3; ln++) begin
      s = "";
      if ($urandom_range(0, 2) == 0) s = "z";
      nb = 1 + $urandom_range(0, 1);
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom);
        s = $sformatf("%s%c%c", s, hex_char(b[7:4], $urandom_range(0, 1) == 1),
                      hex_char(b[3:0], $urandom_range(0, 1) == 1));
      end
      if ($urandom_range(0, 1) == 1) s = {s, "\r"};
      s = {s, "\n"};
      send_line(s);
    end
    tick(2 * BD);

    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_fe", got_fe, exp_fe);
    chk("final_he", got_he, exp_he);
    chk("final_ov", got_ov, exp_ov);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_hex_rx.md
# uart_hex_rx

Receive-side companion to the debug UART transmitter: deserialises 8N1 characters from the host on `uart_rx` and decodes ASCII hex pairs into a byte stream. A line feed terminates a packet. Output is a valid/ready byte stream with a last flag, feeding the frame-injection path into the MII transmit side. All logic runs on `clk_50`, at the same bit period as the transmitter (218 clocks/bit).

## Interface
- `BAUD_DIV`, 218, clocks per bit; must be ≥ 16.
- `clk_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  reset, synchronous, active-high.
- `uart_rx`  in  1  asynchronous serial input, idle high.
- `out_data`  out  8  decoded byte.
- `out_valid`  out  1  `out_data`/`out_last` valid.
- `out_last`  out  1  byte is the final byte of its line.
- `out_ready`  in  1  consumer accepts the byte on a cycle where `out_valid && out_ready`.
- `err_framing`  out  1  one-cycle pulse: stop bit sampled low.
- `err_hex`  out  1  one-cycle pulse: illegal character, or odd nibble count at line feed.
- `overflow`  out  1  one-cycle pulse: a decoded byte was dropped because the output register was full.

## Operation
- Input path: 2-flop synchroniser, both flops reset to 1. Start detection is the falling edge of the synchronised signal.
- Bit receiver states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on a falling edge, load the counter with `BAUD_DIV/2 - 1` and go to START.
  - START: at counter expiry, sample the line. If high, treat as a glitch and return to IDLE. If low, go to DATA with the counter at `BAUD_DIV - 1`.
  - DATA: take 8 samples, one per `BAUD_DIV` clocks, LSB first.
  - STOP: sample the stop bit.
    - Stop bit 1: emit the character and go to IDLE.
    - Stop bit 0: pulse `err_framing`, discard the character, go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE once the synchronised line is high.
- Character decode:
  - `0`–`9`, `A`–`F`, `a`–`f` are nibbles, high nibble first.
  - 0x0D is ignored.
  - 0x0A is end of line.
  - Any other character pulses `err_hex` and clears a half-assembled nibble.
- Pending byte:
  - A completed byte is held in a pending register, not sent immediately.
  - The next completed byte pushes the pending byte to the output with last=0.
  - A line feed pushes the pending byte with last=1.
  - A line feed with no pending byte emits nothing. A line feed with a half nibble also pulses `err_hex` and drops the nibble.
- Output register: single entry.
  - A push while `out_valid && !out_ready` pulses `overflow` and drops the new byte; the held byte is unchanged.
  - A push on the same cycle as an acceptance is legal and refills the register.
- Reset mid-character: the receiver returns to IDLE; nibble, pending byte and output register are cleared.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0x00, all error pulses 0. The receiver resets to IDLE.
- Sample points fall at mid-bit ±1 clock, counted from the synchronised falling edge, which itself lags the pin by 2 cycles.
- Character registered 1 cycle after the stop sample. Decode and any push happen on the next cycle, so `out_valid` rises 2 cycles after the stop-bit sample.
- `err_framing` is asserted on the cycle after the stop-bit sample. `err_hex` and `overflow` are asserted 2 cycles after the stop-bit sample.
- Throughput: at most one character per 10 × `BAUD_DIV` clocks. The consumer must accept within that window to avoid overflow.
- `out_data`/`out_last` hold stable while `out_valid && !out_ready`.

## Structure
- Shared package `uart_pkg`: `BAUD_DIV_DEFAULT`=218, `ASCII_LF`=8'h0A, `ASCII_CR`=8'h0D, bit-receiver state enum.
- Sub-module `uart_rx_byte`: synchroniser plus bit receiver. Outputs `rx_data[7:0]`, `rx_strobe` and `rx_framing_err`. It is reusable by other targets.
- The top level contains the hex decode, the pending register and the output register.

## Test plan
- Send `A`,`5`,LF → one beat `out_data`=0xA5, `out_last`=1, arriving 2 clocks after the LF stop sample.
- Send `0`,`1`,`f`,`F`,CR,LF → beats 0x01/last=0, then 0xFF/last=1. CR causes no effect.
- Character 0x41 with stop bit forced 0, then 2 bit-times high, then `7`,`7`,LF → `err_framing` pulses once, the bad character is discarded, then 0x77/last=1.
- 50-clock low glitch on `uart_rx` → no character and no error pulses; the receiver is back in IDLE.
- `1`,`G`,`2`,`3`,LF → `err_hex` pulses once at `G`, then 0x23/last=1. Separately, `1`,LF → `err_hex` pulses, no beat.
- `out_ready`=0, send `112233`LF → 0x11 is held, 0x22 and 0x33 each pulse `overflow`. Raising `out_ready` yields 0x11/last=0 only.
- Reset asserted mid-DATA, released while the line is still low → no spurious character. The next clean `4`,`2`,LF yields 0x42/last=1.
